// File: rtl/i2c_byte_engine_if.sv
// i2c_byte_engine_if: command/response handshake plus open-drain I2C pin signals.
// master = CSR side and bus pins, slave = the byte engine.
interface i2c_byte_engine_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [1:0] cmd_i;
    logic [7:0] wr_data_i;
    logic       nack_i;
    logic [7:0] rd_data_o;
    logic       rx_nack_o;
    logic       done_o;
    logic       busy_o;
    logic       scl_i;
    logic       sda_i;
    logic       scl_oe_o;
    logic       sda_oe_o;
    modport master (
        output cmd_valid_i, cmd_i, wr_data_i, nack_i, scl_i, sda_i,
        input  cmd_ready_o, rd_data_o, rx_nack_o, done_o, busy_o, scl_oe_o, sda_oe_o
    );
    modport slave (
        input  cmd_valid_i, cmd_i, wr_data_i, nack_i, scl_i, sda_i,
        output cmd_ready_o, rd_data_o, rx_nack_o, done_o, busy_o, scl_oe_o, sda_oe_o
    );
endinterface

// File: rtl/i2c_byte_engine.sv
// i2c_byte_engine: byte-level I2C master (START, STOP, WRITE, READ) with clock stretching.
// Every condition/bit is four phases of CLK_DIV cycles; SCL/SDA are open-drain enables.
module i2c_byte_engine #(
    parameter int CLK_DIV = 125,
    parameter int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    i2c_byte_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, STOP, BIT, DONE} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] tick;
    logic [1:0] phase, op, scl_sync, sda_sync;
    logic [3:0] bit_cnt;
    logic [7:0] sh, rd_data;
    logic nack_q, ack_smp, rx_nack, scl_oe, sda_oe, scl_oe_n, sda_oe_n;
    logic scl_s, sda_s, accept, active, tick_end, stall, phase_end, last_phase, bit_sda;
    assign scl_s      = scl_sync[1];
    assign sda_s      = sda_sync[1];
    assign accept     = state == IDLE && bus.cmd_valid_i;
    assign active     = state inside {START, STOP, BIT};
    assign tick_end   = tick == CNT_W'(CLK_DIV - 1);
    // a slave holding SCL low freezes the counter at the end of P1
    assign stall      = phase == 2'd1 && !scl_s;
    assign phase_end  = active && tick_end && !stall;
    assign last_phase = phase_end && phase == 2'd3;
    assign bit_sda    = op == 2'b10 ? (bit_cnt != 4'd0 && !sh[7]) : (bit_cnt == 4'd0 && !nack_q);
    always_comb begin
        state_n  = state;
        scl_oe_n = scl_oe;
        sda_oe_n = sda_oe;
        if (accept)
            state_n = bus.cmd_i == 2'b00 ? START : bus.cmd_i == 2'b01 ? STOP : BIT;
        else if (state == DONE)
            state_n = IDLE;
        else if (last_phase && (state != BIT || bit_cnt == 4'd0))
            state_n = DONE;
        if (state == START) begin
            sda_oe_n = phase == 2'd0 ? 1'b0 : phase == 2'd2 ? 1'b1 : sda_oe;
            scl_oe_n = phase == 2'd1 ? 1'b0 : phase == 2'd3 ? 1'b1 : scl_oe;
        end else if (state == STOP) begin
            sda_oe_n = phase == 2'd0 ? 1'b1 : phase == 2'd3 ? 1'b0 : sda_oe;
            scl_oe_n = phase == 2'd0 ? 1'b1 : phase == 2'd1 ? 1'b0 : scl_oe;
        end else if (state == BIT) begin
            sda_oe_n = phase == 2'd0 ? bit_sda : sda_oe;
            scl_oe_n = phase == 2'd1 ? 1'b0 : phase == 2'd2 ? scl_oe : 1'b1;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            tick     <= '0;
            phase    <= 2'd0;
            bit_cnt  <= 4'd0;
            op       <= 2'd0;
            nack_q   <= 1'b0;
            sh       <= 8'd0;
            ack_smp  <= 1'b0;
            rd_data  <= 8'd0;
            rx_nack  <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_i};
            sda_sync <= {sda_sync[0], bus.sda_i};
            scl_oe   <= scl_oe_n;
            sda_oe   <= sda_oe_n;
            if (accept) begin
                op      <= bus.cmd_i;
                sh      <= bus.wr_data_i;
                nack_q  <= bus.nack_i;
                bit_cnt <= 4'd8;
                tick    <= '0;
                phase   <= 2'd0;
            end else if (active) begin
                tick <= !tick_end ? tick + CNT_W'(1) : stall ? tick : '0;
                if (phase_end) phase <= phase + 2'd1;
                // reads shift samples in; writes shift the next data bit up to sh[7]
                if (state == BIT && phase == 2'd2 && tick_end) begin
                    if (bit_cnt != 4'd0) sh <= {sh[6:0], sda_s};
                    else ack_smp <= sda_s;
                end
                if (state == BIT && last_phase) begin
                    bit_cnt <= bit_cnt - 4'd1;
                    if (bit_cnt == 4'd0 && op == 2'b11) rd_data <= sh;
                    if (bit_cnt == 4'd0 && op == 2'b10) rx_nack <= ack_smp;
                end
            end
        end
    end
    assign bus.cmd_ready_o = state == IDLE;
    assign bus.busy_o      = state != IDLE;
    assign bus.done_o      = state == DONE;
    assign bus.rd_data_o   = rd_data;
    assign bus.rx_nack_o   = rx_nack;
    assign bus.scl_oe_o    = scl_oe;
    assign bus.sda_oe_o    = sda_oe;
endmodule

// File: tb/tb_i2c_byte_engine.sv
// tb_i2c_byte_engine: directed commands against a small slave model; expected responses are
// queued at issue time and popped by a monitor on every done_o pulse.
module tb_i2c_byte_engine;
    localparam int CD      = 4;
    localparam int STRETCH = 50;
    typedef struct {
        int         exp_cyc;
        bit         byte_cmd;
        logic [8:0] exp_bits;
        int         nr0;
        bit         chk_rd;
        bit         chk_nack;
        logic [7:0] exp_val;
    } item_t;
    logic clk, rst;
    i2c_byte_engine_if bus();
    i2c_byte_engine #(.CLK_DIV(CD)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    item_t q[$];
    item_t it;
    int nvec = 0, nerr = 0, cyc = 0;
    int nr = 0, nf = 0, nstart = 0, nstop = 0, exp_ns = 0, exp_np = 0;
    int pc_base = 0, pc, mode = 0, st_cnt = 0;
    logic [7:0] rbyte = 8'h00;
    logic [8:0] last9 = 9'h0;
    logic pscl = 1'b1, psda = 1'b1, st_req = 1'b0, st_fired = 1'b0;
    logic hold, slave_low;
    // slave: mode 1 ACKs a written byte, mode 2 returns rbyte; pc = SCL pulses since issue
    assign pc        = nf - pc_base;
    assign slave_low = mode == 1 ? pc == 8 : mode == 2 ? (pc < 8 && !rbyte[7 - (pc & 7)]) : 1'b0;
    assign hold      = st_cnt != 0 || (st_req && !st_fired && pc == 4 && !bus.scl_oe_o);
    assign bus.scl_i = ~(bus.scl_oe_o | hold);
    assign bus.sda_i = ~(bus.sda_oe_o | slave_low);
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial forever @(posedge clk) cyc++;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // bus monitor: SDA at each SCL rise, pulse counts, START/STOP conditions
    initial forever @(negedge clk) begin
        if (!pscl && bus.scl_i) begin
            nr++;
            last9 = {last9[7:0], bus.sda_i};
        end
        if (pscl && !bus.scl_i) nf++;
        if (pscl && bus.scl_i && psda && !bus.sda_i) nstart++;
        if (pscl && bus.scl_i && !psda && bus.sda_i) nstop++;
        pscl = bus.scl_i;
        psda = bus.sda_i;
    end
    // stretching slave: holds SCL STRETCH cycles past its own 2-flop view of the release
    initial forever @(negedge clk) begin
        if (!st_req) st_fired = 1'b0;
        if (st_cnt != 0) st_cnt--;
        else if (st_req && !st_fired && pc == 4 && !bus.scl_oe_o) begin
            st_cnt   = STRETCH + 2;
            st_fired = 1'b1;
        end
    end
    initial forever @(negedge clk) begin
        if (rst) q.delete();
        else if (bus.done_o) begin
            if (q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                it = q.pop_front();
                chk("done_cycle", cyc, it.exp_cyc);
                chk("ready_in_done", bus.cmd_ready_o, 0);
                if (it.byte_cmd) begin
                    chk("scl_pulses", nr - it.nr0, 9);
                    chk("sda_bits", last9, it.exp_bits);
                end
                if (it.chk_rd) chk("rd_data", bus.rd_data_o, it.exp_val);
                if (it.chk_nack) chk("rx_nack", bus.rx_nack_o, it.exp_val);
            end
        end
    end
    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic n, input int smode,
                         input logic [7:0] sb, input logic [8:0] eb, input logic [7:0] ev,
                         input int extra, output int acc);
        item_t e;
        @(negedge clk);
        for (int i = 0; i < 2000 && !bus.cmd_ready_o; i++) @(negedge clk);
        acc = -1;
        if (!bus.cmd_ready_o) begin
            nvec++;
            nerr++;
            $display("FAIL ready_timeout: got busy after 2000 cycles expected ready");
            return;
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_i       = c;
        bus.wr_data_i   = d;
        bus.nack_i      = n;
        mode            = smode;
        rbyte           = sb;
        pc_base         = nf;
        acc             = cyc;
        e.exp_cyc  = cyc + (c[1] ? 36 : 4) * CD + 1 + extra;
        e.byte_cmd = c[1];
        e.exp_bits = eb;
        e.nr0      = nr;
        e.chk_rd   = c == 2'b11;
        e.chk_nack = c == 2'b10;
        e.exp_val  = ev;
        q.push_back(e);
        if (c == 2'b00) exp_ns++;
        if (c == 2'b01) exp_np++;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask
    int a0, a1;
    initial begin
        rst = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_i = 2'b00;
        bus.wr_data_i = 8'h00;
        bus.nack_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.cmd_ready_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_scl_oe", bus.scl_oe_o, 0);
        chk("rst_sda_oe", bus.sda_oe_o, 0);
        chk("rst_rd_data", bus.rd_data_o, 0);
        chk("rst_rx_nack", bus.rx_nack_o, 0);
        rst = 1'b0;
        issue(2'b00, 8'h00, 1'b0, 0, 8'h00, 9'h0, 8'h00, 0, a0);
        issue(2'b01, 8'h00, 1'b0, 0, 8'h00, 9'h0, 8'h00, 0, a1);
        chk("b2b_gap", a1 - a0, 4 * CD + 2);
        issue(2'b00, 8'h00, 1'b0, 0, 8'h00, 9'h0, 8'h00, 0, a0);
        issue(2'b10, 8'hA5, 1'b0, 1, 8'h00, 9'h14A, 8'h00, 0, a0);
        issue(2'b01, 8'h00, 1'b0, 0, 8'h00, 9'h0, 8'h00, 0, a0);
        issue(2'b00, 8'h00, 1'b0, 0, 8'h00, 9'h0, 8'h00, 0, a0);
        issue(2'b10, 8'h00, 1'b0, 0, 8'h00, 9'h001, 8'h01, 0, a0);
        issue(2'b01, 8'h00, 1'b0, 0, 8'h00, 9'h0, 8'h00, 0, a0);
        issue(2'b00, 8'h00, 1'b0, 0, 8'h00, 9'h0, 8'h00, 0, a0);
        issue(2'b11, 8'h00, 1'b1, 2, 8'h3C, 9'h079, 8'h3C, 0, a0);
        issue(2'b11, 8'h00, 1'b0, 2, 8'h5A, 9'h0B4, 8'h5A, 0, a0);
        issue(2'b01, 8'h00, 1'b0, 0, 8'h00, 9'h0, 8'h00, 0, a0);
        issue(2'b00, 8'h00, 1'b0, 0, 8'h00, 9'h0, 8'h00, 0, a0);
        st_req = 1'b1;
        issue(2'b10, 8'hA5, 1'b0, 1, 8'h00, 9'h14A, 8'h00, STRETCH + 2, a0);
        chk("busy_mid_write", bus.busy_o, 1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_i = 2'b01;
        repeat (3) @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        issue(2'b01, 8'h00, 1'b0, 0, 8'h00, 9'h0, 8'h00, 0, a0);
        st_req = 1'b0;
        issue(2'b00, 8'h00, 1'b0, 0, 8'h00, 9'h0, 8'h00, 0, a0);
        issue(2'b11, 8'h00, 1'b1, 2, 8'h81, 9'h103, 8'h81, 0, a0);
        for (int i = 0; i < 2000 && pc != 5; i++) @(negedge clk);
        @(negedge clk);
        chk("pre_rst_scl_oe", bus.scl_oe_o, 1);
        #2;
        rst = 1'b1;
        mode = 0;
        #1;
        chk("async_rst_scl_oe", bus.scl_oe_o, 0);
        chk("async_rst_sda_oe", bus.sda_oe_o, 0);
        chk("async_rst_ready", bus.cmd_ready_o, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(2'b00, 8'h00, 1'b0, 0, 8'h00, 9'h0, 8'h00, 0, a0);
        issue(2'b01, 8'h00, 1'b0, 0, 8'h00, 9'h0, 8'h00, 0, a0);
        for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        repeat (4) @(negedge clk);
        chk("start_conditions", nstart, exp_ns);
        chk("stop_conditions", nstop, exp_np);
        chk("end_scl_oe", bus.scl_oe_o, 0);
        chk("end_sda_oe", bus.sda_oe_o, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
